// File: rtl/datapath_core.sv
// Accumulator-CPU datapath: PC, IR, 16-entry register file, ACC, ALU and Zero/Carry flags driven by controller strobes.
// Every strobe takes effect on the next rising clk edge (1-cycle latency); there is no handshake, so the controller paces all updates.
module datapath_core #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              LoadReg,
    input  logic              DumpReg,
    input  logic              LoadAcc,
    input  logic              DumpAcc,
    input  logic              SelAcc0,
    input  logic              SelAcc1,
    input  logic [3:0]        SelALU,
    input  logic [3:0]        ImmediateData,
    input  logic [3:0]        RegNumber,
    input  logic [7:0]        InstrData,
    output logic [PC_W-1:0]   InstrAddr,
    output logic [7:0]        Opcode,
    output logic [DATA_W-1:0] AccOut,
    output logic              Zero,
    output logic              Carry
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1100;
    localparam logic [3:0] ALU_SHL = 4'b1101;

    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] acc;
    logic              zero_flag;
    logic              carry_flag;
    logic [DATA_W-1:0] regs [0:NREG-1];

    logic [DATA_W-1:0] reg_rd;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;
    logic [DATA_W-1:0] acc_next;
    logic [PC_W-1:0]   pc_jump;

    assign reg_rd  = regs[RegNumber];
    assign opnd_b  = DumpReg ? reg_rd : '0;
    assign pc_jump = SelPC ? PC_W'(ImmediateData) : PC_W'(reg_rd);

    // Codes without a defined carry pass the current flag through, so the
    // flag register can load alu_c unconditionally on any ALU write.
    always_comb begin
        sum   = '0;
        alu_r = acc;
        alu_c = carry_flag;
        case (SelALU)
            ALU_ADD: begin
                sum   = {1'b0, acc} + {1'b0, opnd_b};
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            ALU_SUB: begin
                sum   = {1'b0, acc} + {1'b0, ~opnd_b} + {{DATA_W{1'b0}}, 1'b1};
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
            end
            ALU_NOR: alu_r = ~(acc | opnd_b);
            ALU_SHR: begin
                alu_r = acc >> 1;
                alu_c = acc[0];
            end
            ALU_SHL: begin
                alu_r = acc << 1;
                alu_c = acc[DATA_W-1];
            end
            default: alu_r = acc;
        endcase
    end

    always_comb begin
        acc_next = DATA_W'(ImmediateData);
        if (SelAcc1) begin
            acc_next = alu_r;
        end else if (SelAcc0) begin
            acc_next = opnd_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            acc        <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            if (LoadIR) begin
                ir <= InstrData;
            end
            if (LoadPC) begin
                pc <= pc_jump;
            end else if (IncPC) begin
                pc <= pc + 1'b1;
            end
            if (LoadAcc) begin
                acc       <= acc_next;
                zero_flag <= (acc_next == '0);
                if (SelAcc1) begin
                    carry_flag <= alu_c;
                end
            end
        end
    end

    // Register writes take the pre-edge ACC, so a same-cycle ACC load does not leak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (LoadReg && DumpAcc) begin
            regs[RegNumber] <= acc;
        end
    end

    assign InstrAddr = pc;
    assign Opcode    = ir;
    assign AccOut    = acc;
    assign Zero      = zero_flag;
    assign Carry     = carry_flag;

endmodule
